backlight_fader: RTL and testbench
==================================

Name: backlight_fader

Overview:
- Parametrised successor of the LCD backlight inactivity timer. Multiple asynchronous activity sources feed a millisecond-resolution inactivity counter with a selectable timeout.
- On timeout, the backlight does not switch off abruptly. It fades down through a PWM duty ramp.
- Sits in the clk27 domain beside the CPU sys_ctrl register. Its output drives LCD_BL.

Parameters:
- NUM_EVT, 4: number of toggle-type activity inputs.
- CLK_PER_MS, 27000: clk27 cycles per millisecond tick.
- MS_W, 15: inactivity millisecond counter width. The counter saturates.
- PWM_W, 8: brightness/PWM resolution.
- T1_MS, 3000: timeout for bl_time=01.
- T2_MS, 10000: timeout for bl_time=10.
- T3_MS, 30000: timeout for bl_time=11.
- FADE_STEP_MS, 4: milliseconds per one-LSB duty decrement during fade.

Ports:
- clk27  in  1  system clock, 27 MHz.
- po_reset_n  in  1  reset, asynchronous, active-low.
- evt_toggle  in  NUM_EVT  async activity inputs; any level change counts as one event.
- evt_pulse  in  1  synchronous single-cycle activity strobe (clk27 domain).
- enable  in  1  backlight master enable.
- force_on  in  1  hold full brightness and suppress timeout (e.g. latency tester active).
- bl_time  in  2  timeout select: 00 never, 01 T1, 10 T2, 11 T3.
- bright_level  in  PWM_W  target on-brightness (duty).
- bl_out  out  1  PWM backlight drive.
- timed_out  out  1  high in FADE or DARK.
- ms_elapsed  out  MS_W  current inactivity milliseconds (saturating).

Behaviour:
- Reset values: bl_out=0, timed_out=0, ms_elapsed=0, prescaler=0, pwm_cnt=0, duty_cur=0, state=ON. The evt_toggle synchroniser flops and the previous-value register reset to 0.
- Event path:
  - evt_toggle passes through a 2-flop synchroniser, then compares against a registered previous value.
  - Any bit differing produces evt_hit.
  - evt_hit is ORed with evt_pulse.
  - Latency: a toggle input change clears the counter on the 3rd clk27 edge. evt_pulse clears it on the 1st edge.
- Prescaler: counts 0..CLK_PER_MS-1 and emits ms_tick on wrap.
- Inactivity counter: ms_elapsed increments on ms_tick until it saturates at 2^MS_W-1.
- An event clears both the prescaler and ms_elapsed. If an event and ms_tick fall in the same cycle, the event wins.
- Timeout limit: lim = T1/T2/T3 per bl_time. expired = (bl_time!=00) && (ms_elapsed >= lim). The comparison is evaluated every cycle, so a bl_time change takes effect immediately.
- States:
  - ON: duty_cur = bright_level each cycle. When expired && !force_on, go to FADE and clear fade_ctr.
  - FADE: fade_ctr counts ms_tick. Every FADE_STEP_MS ticks, duty_cur decrements by 1. If bright_level < duty_cur, duty_cur is clamped to bright_level. When duty_cur==0, go to DARK.
  - DARK: duty_cur=0.
  - From FADE or DARK, go to ON (duty_cur = bright_level on the same edge) on any of: event, force_on=1, bl_time=00, or !expired (e.g. bl_time raised above ms_elapsed).
- force_on in ON: counter keeps running, but no transition occurs.
- PWM:
  - pwm_cnt is free-running, 0..2^PWM_W-2 (period 2^PWM_W-1).
  - bl_out registered = enable && (duty_cur > pwm_cnt).
  - duty 2^PWM_W-1 gives constant high; duty 0 gives constant low.
- enable=0 forces bl_out=0 without disturbing the counters or state.
- timed_out is registered: 1 in FADE/DARK, 0 in ON.
- A reset asserted mid-fade returns every output to its reset value asynchronously.

Decomposition:
- Shared package backlight_pkg holds:
  - the state enum {ON, FADE, DARK} (2 bits);
  - default T1/T2/T3 constants;
  - the bl_time encoding constants.
- One sub-module, ms_prescaler (CLK_PER_MS param), provides sync_clr and the ms_tick output. It is reusable by other ms-timers in the design.

Test Plan (bench params CLK_PER_MS=4, T1=10, T2=20, T3=40, PWM_W=4, FADE_STEP_MS=1, NUM_EVT=2):
- Reset, then bl_time=01, bright_level=15, enable=1, no events:
  - bl_out constant 1 up to 40 cycles (10 ms);
  - timed_out rises when ms_elapsed reaches 10;
  - duty drops 15→0 at 1 per ms;
  - DARK reached after 15 ms more, with bl_out=0.
- During FADE at duty=7, toggle evt_toggle[1] → 3 cycles later ms_elapsed=0, state ON, duty=15, timed_out=0.
- evt_pulse and ms_tick in the same cycle at ms_elapsed=9 → ms_elapsed=0 next cycle, no timeout.
- bl_time=00 for 200 ms → ms_elapsed=200, state ON. Then set bl_time=01 → FADE next cycle. Then bl_time=11 → ON next cycle.
- force_on=1 with bl_time=01 for 100 ms → never leaves ON, bl_out duty 15. Release force_on → FADE next cycle.
- bright_level=8, enable=1 → bl_out high 8 of every 15 cycles. Set enable=0 → bl_out=0, ms_elapsed still counting. Assert po_reset_n=0 mid-fade → all outputs 0 immediately.

Source files
------------

// File: rtl/backlight_pkg.sv
// Shared types and constants for the backlight fader.
// State encoding, default timeouts and bl_time select codes.
package backlight_pkg;

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_FADE = 2'd1,
        ST_DARK = 2'd2
    } bl_state_t;

    localparam int T1_MS_DEF = 3000;
    localparam int T2_MS_DEF = 10000;
    localparam int T3_MS_DEF = 30000;

    localparam logic [1:0] BL_NEVER = 2'b00;
    localparam logic [1:0] BL_T1    = 2'b01;
    localparam logic [1:0] BL_T2    = 2'b10;
    localparam logic [1:0] BL_T3    = 2'b11;

endpackage

// File: rtl/backlight_fader_ms_prescaler.sv
// Millisecond prescaler: divides clk27 down to a one-cycle ms_tick.
// sync_clr restarts the millisecond so the next tick is a full ms away.
module ms_prescaler #(
    parameter int CLK_PER_MS = 27000
) (
    input  logic clk27,
    input  logic po_reset_n,
    input  logic sync_clr,
    output logic ms_tick
);

    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] cnt;

    assign ms_tick = (cnt == LAST);

    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            cnt <= '0;
        end else if (sync_clr || ms_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/backlight_fader.sv
// Backlight inactivity timer with a PWM fade-down ramp on timeout.
// Activity from toggle inputs or a sync strobe restores full brightness.
module backlight_fader
    import backlight_pkg::*;
#(
    parameter int NUM_EVT      = 4,
    parameter int CLK_PER_MS   = 27000,
    parameter int MS_W         = 15,
    parameter int PWM_W        = 8,
    parameter int T1_MS        = T1_MS_DEF,
    parameter int T2_MS        = T2_MS_DEF,
    parameter int T3_MS        = T3_MS_DEF,
    parameter int FADE_STEP_MS = 4
) (
    input  logic               clk27,
    input  logic               po_reset_n,
    input  logic [NUM_EVT-1:0] evt_toggle,
    input  logic               evt_pulse,
    input  logic               enable,
    input  logic               force_on,
    input  logic [1:0]         bl_time,
    input  logic [PWM_W-1:0]   bright_level,
    output logic               bl_out,
    output logic               timed_out,
    output logic [MS_W-1:0]    ms_elapsed
);

    localparam int FW = (FADE_STEP_MS > 1) ? $clog2(FADE_STEP_MS) : 1;
    localparam logic [FW-1:0]    FADE_LAST = FW'(FADE_STEP_MS - 1);
    localparam logic [MS_W-1:0]  MS_MAX    = {MS_W{1'b1}};
    localparam logic [PWM_W-1:0] PWM_LAST  = PWM_W'((1 << PWM_W) - 2);

    logic [NUM_EVT-1:0] tog_s1;
    logic [NUM_EVT-1:0] tog_s2;
    logic [NUM_EVT-1:0] tog_prev;
    logic               evt_hit;
    logic               evt;
    logic               ms_tick;
    logic [MS_W-1:0]    lim;
    logic               expired;
    logic               wake;

    bl_state_t          state_q;
    bl_state_t          state_d;
    logic [PWM_W-1:0]   duty_cur;
    logic [PWM_W-1:0]   duty_d;
    logic [FW-1:0]      fade_ctr;
    logic [FW-1:0]      fade_d;
    logic [PWM_W-1:0]   pwm_cnt;

    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            tog_s1   <= '0;
            tog_s2   <= '0;
            tog_prev <= '0;
        end else begin
            tog_s1   <= evt_toggle;
            tog_s2   <= tog_s1;
            tog_prev <= tog_s2;
        end
    end

    assign evt_hit = |(tog_s2 ^ tog_prev);
    assign evt     = evt_hit | evt_pulse;

    ms_prescaler #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_presc (
        .clk27      (clk27),
        .po_reset_n (po_reset_n),
        .sync_clr   (evt),
        .ms_tick    (ms_tick)
    );

    // An event in the same cycle as a tick wins and clears the count.
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            ms_elapsed <= '0;
        end else if (evt) begin
            ms_elapsed <= '0;
        end else if (ms_tick && (ms_elapsed != MS_MAX)) begin
            ms_elapsed <= ms_elapsed + MS_W'(1);
        end
    end

    always_comb begin
        lim = '0;
        unique case (bl_time)
            BL_NEVER: lim = '0;
            BL_T1:    lim = MS_W'(T1_MS);
            BL_T2:    lim = MS_W'(T2_MS);
            BL_T3:    lim = MS_W'(T3_MS);
        endcase
    end

    assign expired = (bl_time != BL_NEVER) && (ms_elapsed >= lim);
    assign wake    = evt | force_on | (bl_time == BL_NEVER) | !expired;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_cur;
        fade_d  = fade_ctr;
        unique case (state_q)
            ST_ON: begin
                duty_d = bright_level;
                if (expired && !force_on && !evt) begin
                    state_d = ST_FADE;
                    fade_d  = '0;
                end
            end
            ST_FADE: begin
                if (wake) begin
                    state_d = ST_ON;
                    duty_d  = bright_level;
                end else if (duty_cur == '0) begin
                    state_d = ST_DARK;
                end else if (bright_level < duty_cur) begin
                    duty_d = bright_level;
                end else if (ms_tick) begin
                    if (fade_ctr == FADE_LAST) begin
                        fade_d = '0;
                        duty_d = duty_cur - PWM_W'(1);
                    end else begin
                        fade_d = fade_ctr + FW'(1);
                    end
                end
            end
            ST_DARK: begin
                duty_d = '0;
                if (wake) begin
                    state_d = ST_ON;
                    duty_d  = bright_level;
                end
            end
            default: begin
                state_d = ST_ON;
                duty_d  = bright_level;
            end
        endcase
    end

    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            state_q   <= ST_ON;
            duty_cur  <= '0;
            fade_ctr  <= '0;
            timed_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_cur  <= duty_d;
            fade_ctr  <= fade_d;
            timed_out <= (state_d != ST_ON);
        end
    end

    // Period is 2^PWM_W-1 so full-scale duty yields a constant high.
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            pwm_cnt <= '0;
            bl_out  <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_W'(1);
            bl_out  <= enable && (duty_cur > pwm_cnt);
        end
    end

endmodule

// File: tb/tb_backlight_fader.sv
// Directed bench for backlight_fader: vector table plus
// hand sequences for PWM duty, enable gating and async reset.
module tb_backlight_fader;

    logic       clk27;
    logic       po_reset_n;
    logic [1:0] evt_toggle;
    logic       evt_pulse;
    logic       enable;
    logic       force_on;
    logic [1:0] bl_time;
    logic [3:0] bright_level;
    logic       bl_out;
    logic       timed_out;
    logic [7:0] ms_elapsed;

    int n_total;
    int n_pass;

    backlight_fader #(
        .NUM_EVT      (2),
        .CLK_PER_MS   (4),
        .MS_W         (8),
        .PWM_W        (4),
        .T1_MS        (10),
        .T2_MS        (20),
        .T3_MS        (40),
        .FADE_STEP_MS (1)
    ) dut (
        .clk27        (clk27),
        .po_reset_n   (po_reset_n),
        .evt_toggle   (evt_toggle),
        .evt_pulse    (evt_pulse),
        .enable       (enable),
        .force_on     (force_on),
        .bl_time      (bl_time),
        .bright_level (bright_level),
        .bl_out       (bl_out),
        .timed_out    (timed_out),
        .ms_elapsed   (ms_elapsed)
    );

    initial begin
        clk27 = 1'b0;
        forever #5 clk27 = ~clk27;
    end

    typedef struct {
        string      name;
        logic [1:0] tog;
        logic       pulse;
        logic [1:0] bt;
        logic       frc;
        logic [3:0] br;
        int         adv;
        int         e_ms;
        int         e_to;
        int         e_duty;
        int         e_st;
        int         e_bl;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk27);
        #1;
    endtask

    task automatic add(input string name, input logic [1:0] tog,
                       input logic pulse, input logic [1:0] bt,
                       input logic frc, input logic [3:0] br,
                       input int adv, input int e_ms, input int e_to,
                       input int e_duty, input int e_st, input int e_bl);
        vec_t v;
        v.name = name;   v.tog = tog;     v.pulse = pulse;
        v.bt = bt;       v.frc = frc;     v.br = br;
        v.adv = adv;     v.e_ms = e_ms;   v.e_to = e_to;
        v.e_duty = e_duty; v.e_st = e_st; v.e_bl = e_bl;
        vt.push_back(v);
    endtask

    initial begin
        int hi;
        int ms_a;
        n_total = 0;
        n_pass  = 0;

        // name, tog, pulse, bt, force, bright, adv | ms, to, duty, st, bl
        add("first",      2'b00, 0, 2'b01, 0, 15,   1,   0, 0, 15, 0, 0);
        add("bl_on",      2'b00, 0, 2'b01, 0, 15,   1,   0, 0, 15, 0, 1);
        add("pre_to",     2'b00, 0, 2'b01, 0, 15,  38,  10, 0, 15, 0, 1);
        add("to_rise",    2'b00, 0, 2'b01, 0, 15,   1,  10, 1, 15, 1, 1);
        add("fade14",     2'b00, 0, 2'b01, 0, 15,   3,  11, 1, 14, 1, -1);
        add("fade7",      2'b00, 0, 2'b01, 0, 15,  28,  18, 1,  7, 1, -1);
        add("tog_wait",   2'b10, 0, 2'b01, 0, 15,   2,  18, 1,  7, 1, -1);
        add("tog_wake",   2'b10, 0, 2'b01, 0, 15,   1,   0, 0, 15, 0, -1);
        add("ms9",        2'b10, 0, 2'b01, 0, 15,  36,   9, 0, 15, 0, 1);
        add("ms9_tick",   2'b10, 0, 2'b01, 0, 15,   3,   9, 0, 15, 0, 1);
        add("pulse_tick", 2'b10, 1, 2'b01, 0, 15,   1,   0, 0, 15, 0, 1);
        add("after_pls",  2'b10, 0, 2'b01, 0, 15,   8,   2, 0, 15, 0, 1);
        add("to2",        2'b10, 0, 2'b01, 0, 15,  32,  10, 0, 15, 0, 1);
        add("fade2",      2'b10, 0, 2'b01, 0, 15,   1,  10, 1, 15, 1, 1);
        add("fade_end",   2'b10, 0, 2'b01, 0, 15,  59,  25, 1,  0, 1, -1);
        add("dark",       2'b10, 0, 2'b01, 0, 15,   1,  25, 1,  0, 2, 0);
        add("dark_hold",  2'b10, 0, 2'b01, 0, 15,  10,  27, 1,  0, 2, 0);
        add("b00_clr",    2'b10, 1, 2'b00, 0, 15,   1,   0, 0, 15, 0, 0);
        add("b00_200",    2'b10, 0, 2'b00, 0, 15, 800, 200, 0, 15, 0, 1);
        add("ms_sat",     2'b10, 0, 2'b00, 0, 15, 400, 255, 0, 15, 0, 1);
        add("clr15",      2'b10, 1, 2'b00, 0, 15,   1,   0, 0, 15, 0, 1);
        add("ms15",       2'b10, 0, 2'b00, 0, 15,  60,  15, 0, 15, 0, 1);
        add("b01_fade",   2'b10, 0, 2'b01, 0, 15,   1,  15, 1, 15, 1, 1);
        add("b11_on",     2'b10, 0, 2'b11, 0, 15,   1,  15, 0, 15, 0, 1);
        add("force_clr",  2'b10, 1, 2'b01, 1, 15,   1,   0, 0, 15, 0, 1);
        add("force_100",  2'b10, 0, 2'b01, 1, 15, 400, 100, 0, 15, 0, 1);
        add("force_rel",  2'b10, 0, 2'b01, 0, 15,   1, 100, 1, 15, 1, 1);
        add("clamp",      2'b10, 0, 2'b01, 0,  5,   1, 100, 1,  5, 1, -1);

        po_reset_n   = 1'b0;
        evt_toggle   = 2'b00;
        evt_pulse    = 1'b0;
        enable       = 1'b1;
        force_on     = 1'b0;
        bl_time      = 2'b01;
        bright_level = 4'd15;
        step(1);
        chk("rst_bl", int'(bl_out), 0);
        chk("rst_to", int'(timed_out), 0);
        chk("rst_ms", int'(ms_elapsed), 0);
        po_reset_n = 1'b1;

        foreach (vt[i]) begin
            evt_toggle   = vt[i].tog;
            evt_pulse    = vt[i].pulse;
            bl_time      = vt[i].bt;
            force_on     = vt[i].frc;
            bright_level = vt[i].br;
            step(vt[i].adv);
            chk({vt[i].name, "_ms"}, int'(ms_elapsed), vt[i].e_ms);
            chk({vt[i].name, "_to"}, int'(timed_out), vt[i].e_to);
            chk({vt[i].name, "_duty"}, int'(dut.duty_cur), vt[i].e_duty);
            chk({vt[i].name, "_st"}, int'(dut.state_q), vt[i].e_st);
            if (vt[i].e_bl >= 0)
                chk({vt[i].name, "_bl"}, int'(bl_out), vt[i].e_bl);
        end

        // PWM duty 8 over one 15-cycle period
        evt_pulse    = 1'b0;
        force_on     = 1'b0;
        bl_time      = 2'b00;
        bright_level = 4'd8;
        evt_pulse    = 1'b1;
        step(1);
        evt_pulse = 1'b0;
        step(2);
        hi = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            hi += int'(bl_out);
        end
        chk("pwm8_high", hi, 8);

        enable = 1'b0;
        step(1);
        hi = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            hi += int'(bl_out);
        end
        chk("en0_high", hi, 0);
        ms_a = int'(ms_elapsed);
        step(8);
        chk("en0_ms_run", int'(ms_elapsed), ms_a + 2);

        // Async reset in the middle of a fade
        enable       = 1'b1;
        bright_level = 4'd15;
        bl_time      = 2'b01;
        evt_pulse    = 1'b1;
        step(1);
        evt_pulse = 1'b0;
        step(44);
        chk("mid_to", int'(timed_out), 1);
        chk("mid_duty", int'(dut.duty_cur), 14);
        #2;
        po_reset_n = 1'b0;
        #1;
        chk("arst_bl", int'(bl_out), 0);
        chk("arst_to", int'(timed_out), 0);
        chk("arst_ms", int'(ms_elapsed), 0);
        chk("arst_duty", int'(dut.duty_cur), 0);
        chk("arst_st", int'(dut.state_q), 0);
        step(1);
        po_reset_n = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
